// File: rtl/aes_regfile_if.sv
// Internal write/read strobe bus between the AXI-Lite slave and aes_regfile.
// The slave side issues one-cycle write pulses and samples combinational read data.
interface aes_regfile_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]           rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/aes_regfile.sv
// AES accelerator control/status register bank.
// Holds KEY/DIN, sequences one block operation on the core, captures DOUT,
// and reports BUSY/DONE/ERR plus a saturating cycle count.
// Optional interrupt output enabled by defining AES_RF_IRQ_EN.
module aes_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    aes_regfile_if.slave  bus,
    output logic          core_start_o,
    output logic          core_mode_o,
    output logic [127:0]  core_key_o,
    output logic [127:0]  core_din_o,
    input  logic          core_done_i,
    input  logic [127:0]  core_dout_i
`ifdef AES_RF_IRQ_EN
    ,
    output logic          irq_o
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  irq_en_q, irq_en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  core_start_q, core_start_d;
    logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
    logic [DATA_WIDTH-1:0] key_q  [4];
    logic [DATA_WIDTH-1:0] key_d  [4];
    logic [DATA_WIDTH-1:0] din_q  [4];
    logic [DATA_WIDTH-1:0] din_d  [4];
    logic [DATA_WIDTH-1:0] dout_q [4];
    logic [DATA_WIDTH-1:0] dout_d [4];
`ifdef AES_RF_IRQ_EN
    logic                  irq_q, irq_d;
`endif

    logic [5:0] wa, ra;
    logic       wr_ctrl, wr_start, wr_key, wr_din, wr_status;
    logic       done_set, done_clr, err_set, err_clr;

    // Upper address bits, byte-offset bits and rd_en carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.rd_en,
                           bus.wr_addr[ADDR_WIDTH-1:8], bus.wr_addr[1:0],
                           bus.rd_addr[ADDR_WIDTH-1:8], bus.rd_addr[1:0]};

    assign wa = bus.wr_addr[7:2];
    assign ra = bus.rd_addr[7:2];

    assign wr_ctrl   = bus.wr_en && (wa == 6'd0) && bus.wr_strb[0];
    assign wr_start  = wr_ctrl && bus.wr_data[0];
    assign wr_status = bus.wr_en && (wa == 6'd1) && bus.wr_strb[0];
    assign wr_key    = bus.wr_en && (wa[5:2] == 4'd1);
    assign wr_din    = bus.wr_en && (wa[5:2] == 4'd2);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Next-state for the FSM and every register; writes are gated by state.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        irq_en_d     = irq_en_q;
        cycles_d     = cycles_q;
        key_d        = key_q;
        din_d        = din_q;
        dout_d       = dout_q;
        core_start_d = 1'b0;
        done_set     = 1'b0;
        done_clr     = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;

        if (wr_ctrl) begin
            irq_en_d = bus.wr_data[2];
        end

        case (state_q)
            IDLE: begin
                if (wr_ctrl) begin
                    mode_d = bus.wr_data[1];
                end
                if (wr_key) begin
                    key_d[wa[1:0]] = merge_bytes(key_q[wa[1:0]], bus.wr_data, bus.wr_strb);
                end
                if (wr_din) begin
                    din_d[wa[1:0]] = merge_bytes(din_q[wa[1:0]], bus.wr_data, bus.wr_strb);
                end
                if (wr_start) begin
                    state_d      = RUN;
                    core_start_d = 1'b1;
                    cycles_d     = '0;
                end
            end
            RUN: begin
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
                // A CTRL write counts as a MODE write only if it starts or changes
                // MODE, so toggling IRQ_EN alone during RUN is not an error.
                if (wr_key || wr_din ||
                    (wr_ctrl && (bus.wr_data[0] || (bus.wr_data[1] != mode_q)))) begin
                    err_set = 1'b1;
                end
                if (core_done_i) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        dout_d[i] = core_dout_i[32*i +: 32];
                    end
                    done_set = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_status) begin
            done_clr = bus.wr_data[1];
            err_clr  = bus.wr_data[2];
        end
    end

    // Set has priority over W1C for the sticky status bits.
    assign done_d = (done_q & ~done_clr) | done_set;
    assign err_d  = (err_q  & ~err_clr)  | err_set;
`ifdef AES_RF_IRQ_EN
    assign irq_d  = done_d & irq_en_d;
`endif

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
            cycles_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                key_q[i]  <= '0;
                din_q[i]  <= '0;
                dout_q[i] <= '0;
            end
`ifdef AES_RF_IRQ_EN
            irq_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
            cycles_q     <= cycles_d;
            key_q        <= key_d;
            din_q        <= din_d;
            dout_q       <= dout_d;
`ifdef AES_RF_IRQ_EN
            irq_q        <= irq_d;
`endif
        end
    end

    // Zero-latency read mux; unmapped offsets return 0.
    always_comb begin
        bus.rd_data = '0;
        case (ra)
            6'd0: bus.rd_data = {29'b0, irq_en_q, mode_q, 1'b0};
            6'd1: bus.rd_data = {29'b0, err_q, done_q, state_q == RUN};
            6'd2: bus.rd_data = cycles_q;
            default: begin
                case (ra[5:2])
                    4'd1:    bus.rd_data = key_q[ra[1:0]];
                    4'd2:    bus.rd_data = din_q[ra[1:0]];
                    4'd3:    bus.rd_data = dout_q[ra[1:0]];
                    default: bus.rd_data = '0;
                endcase
            end
        endcase
    end

    assign core_start_o = core_start_q;
    assign core_mode_o  = mode_q;
    assign core_key_o   = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign core_din_o   = {din_q[3], din_q[2], din_q[1], din_q[0]};
`ifdef AES_RF_IRQ_EN
    assign irq_o        = irq_q;
`endif

endmodule
